// File: rtl/centroid_update_if.sv
// Beat stream in (label, x, y, last) and centroid result stream out.
// The master drives beats and accepts results; the slave is the accumulator.
interface centroid_update_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_label;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_y;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_id;
  logic [DW-1:0] out_x;
  logic [DW-1:0] out_y;
  logic          out_empty;

  modport master (
    output in_valid, in_label, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_id, out_x, out_y, out_empty
  );

  modport slave (
    input  in_valid, in_label, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_id, out_x, out_y, out_empty
  );
endinterface

// File: rtl/centroid_update.sv
// Per-cluster coordinate accumulator for 4 K-means clusters; emits one mean
// per cluster at frame end using two parallel restoring dividers.
//
// state | meaning
// ACCUM | accept beats, add into sum/count of the labelled cluster
// DIV   | load divider for cluster k, then SW shift/subtract steps
// OUT   | present result k until the downstream handshake
module centroid_update #(
  parameter int DW = 8,
  parameter int CW = 10
) (
  input  logic              clk,
  input  logic              reset,
  centroid_update_if.slave  bus,
  output logic              ovf,
  output logic              busy
);

  localparam int SW = DW + CW;
  localparam int IW = $clog2(SW + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0] ITR_LAST = IW'(SW);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0] sum_x [4];
  logic [SW-1:0] sum_y [4];
  logic [CW-1:0] cnt   [4];

  logic [1:0]    k;
  logic [IW-1:0] itr;
  logic [SW-1:0] qx, qy;
  logic [CW-1:0] rx, ry;

  logic [1:0]    out_id_q;
  logic [DW-1:0] out_x_q, out_y_q;
  logic          out_empty_q;

  logic [CW-1:0] cnt_k;
  logic          div_done;
  logic [CW:0]   shx, shy, dfx, dfy;
  logic          gex, gey;
  logic [SW-1:0] nqx, nqy;
  logic [CW-1:0] nrx, nry;

  // Divisor and dividends stay untouched in their arrays while a cluster divides.
  always_comb begin
    cnt_k    = cnt[k];
    div_done = (itr != '0) && ((cnt_k == '0) || (itr == ITR_LAST));
    shx      = {rx, qx[SW-1]};
    shy      = {ry, qy[SW-1]};
    gex      = (shx >= {1'b0, cnt_k});
    gey      = (shy >= {1'b0, cnt_k});
    dfx      = gex ? (shx - {1'b0, cnt_k}) : shx;
    dfy      = gey ? (shy - {1'b0, cnt_k}) : shy;
    nrx      = dfx[CW-1:0];
    nry      = dfy[CW-1:0];
    nqx      = {qx[SW-2:0], gex};
    nqy      = {qy[SW-2:0], gey};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (bus.in_valid && bus.in_last) state_nxt = DIV;
      DIV:   if (div_done) state_nxt = OUT;
      OUT:   if (bus.out_ready) state_nxt = (k == 2'd3) ? ACCUM : DIV;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.out_valid = (state == OUT);
    busy          = (state != ACCUM);
  end

  assign bus.out_id    = out_id_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_empty = out_empty_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
        cnt[i]   <= '0;
      end
      ovf         <= 1'b0;
      k           <= '0;
      itr         <= '0;
      qx          <= '0;
      qy          <= '0;
      rx          <= '0;
      ry          <= '0;
      out_id_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_empty_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            // A saturated cluster drops the point entirely so its mean stays exact.
            if (cnt[bus.in_label] == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              sum_x[bus.in_label] <= sum_x[bus.in_label] + {{CW{1'b0}}, bus.in_x};
              sum_y[bus.in_label] <= sum_y[bus.in_label] + {{CW{1'b0}}, bus.in_y};
              cnt[bus.in_label]   <= cnt[bus.in_label] + 1'b1;
            end
            if (bus.in_last) begin
              k   <= '0;
              itr <= '0;
            end
          end
        end
        DIV: begin
          if (itr == '0) begin
            qx  <= sum_x[k];
            qy  <= sum_y[k];
            rx  <= '0;
            ry  <= '0;
            itr <= IW'(1);
          end else if (cnt_k == '0) begin
            out_id_q    <= k;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_empty_q <= 1'b1;
            itr         <= '0;
          end else begin
            qx <= nqx;
            qy <= nqy;
            rx <= nrx;
            ry <= nry;
            if (itr == ITR_LAST) begin
              out_id_q    <= k;
              out_x_q     <= nqx[DW-1:0];
              out_y_q     <= nqy[DW-1:0];
              out_empty_q <= 1'b0;
              itr         <= '0;
            end else begin
              itr <= itr + 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            k <= k + 2'd1;
            if (k == 2'd3) begin
              for (int i = 0; i < 4; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
              end
              ovf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
